instr_fetch_unit: RTL and testbench

Multi-cycle instruction fetch stage directly upstream of the main control unit. Owns the PC and issues fetches to instruction memory over a valid/ready request and valid response handshake. Latches the returned word and presents the decoded fields (opcode, funct3, funct7, rs1, rs2, rd) to control and the datapath. Advances the PC from the control unit's pc_src decision when the datapath signals completion.

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches over a valid/ready
// request + valid response handshake, and presents decoded fields to control.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic            exec_done,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_fault,
  output logic [31:0]     instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_FAULT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] next_pc;

  assign pc_plus4  = pc + XLEN'(4);
  assign imem_addr = pc;
  assign next_pc   = pc_src ? branch_target : pc_plus4;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // imem_req_valid is registered: it is low through the reset cycle and rises
  // one cycle later, so a response still in flight from before reset lands in
  // FETCH and is dropped.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // overrides every state, including a half-finished handshake.
    if (!rst_n) begin
      state          <= S_FETCH;
      pc             <= RESET_PC;
      instr          <= NOP;
      instr_valid    <= 1'b0;
      fetch_fault    <= 1'b0;
      instret        <= '0;
      imem_req_valid <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= S_WAIT;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            instret     <= instret + 32'd1;
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              state       <= S_FAULT;
            end else begin
              pc             <= next_pc;
              imem_req_valid <= 1'b1;
              state          <= S_FETCH;
            end
          end
        end
        S_FAULT: begin
          // Terminal until reset; all state is frozen.
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential flow, branches, backpressure,
// misaligned-target fault, reset mid-handshake and PC wrap.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        exec_done;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;
  logic [31:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_rdata     (imem_rdata),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .exec_done      (exec_done),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .opcode         (opcode),
    .rd             (rd),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct7         (funct7),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_fault    (fetch_fault),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a request, optionally stalls it with ready low (while driving
  // stale exec_done/pc_src that must be ignored), accepts it, then returns data.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                       input int stall, input bit noise);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      step();
      n++;
    end
    check("req_valid_seen", 32'(imem_req_valid), 32'd1);
    check("req_addr", imem_addr, exp_addr);
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        exec_done     = 1'b1;
        pc_src        = 1'b1;
        branch_target = 32'h80;
      end
      step();
      check("stall_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_addr, exp_addr);
    end
    exec_done      = 1'b0;
    pc_src         = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("wait_req_low", 32'(imem_req_valid), 32'd0);
    check("wait_instr_valid", 32'(instr_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_rdata      = data;
    step();
    imem_resp_valid = 1'b0;
    check("exec_instr_valid", 32'(instr_valid), 32'd1);
    check("exec_instr", instr, data);
    check("exec_pc", pc, exp_addr);
  endtask

  task automatic exec(input logic take, input logic [31:0] target);
    step();
    exec_done     = 1'b1;
    pc_src        = take;
    branch_target = target;
    step();
    exec_done     = 1'b0;
    pc_src        = 1'b0;
    branch_target = 32'h0;
    check("retire_instr_valid", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata      = 32'h0;
    pc_src          = 1'b0;
    branch_target   = 32'h0;
    exec_done       = 1'b0;
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b1;

    // addi x1, x0, 5
    fetch(32'h0, 32'h0050_0093, 0, 1'b0);
    check("f_opcode", 32'(opcode), 32'h13);
    check("f_rd", 32'(rd), 32'd1);
    check("f_rs1", 32'(rs1), 32'd0);
    check("f_funct3", 32'(funct3), 32'd0);
    check("f_rs2", 32'(rs2), 32'd5);
    check("f_funct7", 32'(funct7), 32'd0);
    check("f_pc_plus4", pc_plus4, 32'h4);
    exec(1'b0, 32'h0);
    check("seq_pc_4", pc, 32'h4);

    // add x3, x1, x2 ; sub x5, x6, x7 ; or x10, x11, x12
    fetch(32'h4, 32'h0020_81B3, 0, 1'b0);
    check("add_rs2", 32'(rs2), 32'd2);
    exec(1'b0, 32'h0);
    fetch(32'h8, 32'h4073_02B3, 0, 1'b0);
    check("sub_funct7", 32'(funct7), 32'h20);
    check("sub_rd", 32'(rd), 32'd5);
    exec(1'b0, 32'h0);
    fetch(32'hC, 32'h00C5_E533, 0, 1'b0);
    check("or_funct3", 32'(funct3), 32'd6);
    check("or_rs1", 32'(rs1), 32'd11);
    exec(1'b0, 32'h0);
    check("seq_instret", instret, 32'd4);
    check("seq_pc_10", pc, 32'h10);

    // Backpressure for 5 cycles with stray exec_done/pc_src outside EXEC.
    fetch(32'h10, 32'h0000_0013, 5, 1'b1);
    check("noise_instret", instret, 32'd4);
    exec(1'b1, 32'h40);
    check("br_pc", pc, 32'h40);
    check("br_instret", instret, 32'd5);
    fetch(32'h40, 32'h0000_0013, 0, 1'b0);

    // Misaligned branch target.
    exec(1'b1, 32'h42);
    check("fault_flag", 32'(fetch_fault), 32'd1);
    check("fault_pc", pc, 32'h40);
    check("fault_instret", instret, 32'd6);
    exec_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fault_no_req", 32'(imem_req_valid), 32'd0);
    end
    exec_done = 1'b0;
    check("fault_frozen_instret", instret, 32'd6);
    check("fault_instr_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("clr_fault", 32'(fetch_fault), 32'd0);
    check("clr_pc", pc, 32'h0);
    check("clr_instret", instret, 32'd0);

    // Reset while in WAIT, response arrives the cycle after reset.
    step();
    check("rw_req", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    check("rw_instr", instr, 32'h0000_0013);
    check("rw_instr_valid", 32'(instr_valid), 32'd0);
    check("rw_new_req", 32'(imem_req_valid), 32'd1);
    check("rw_addr", imem_addr, 32'h0);

    // PC wrap at 2^32.
    fetch(32'h0, 32'h0000_0013, 0, 1'b0);
    exec(1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0013, 0, 1'b0);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    exec(1'b0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_instret", instret, 32'd2);
    check("wrap_fault", 32'(fetch_fault), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
